load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side controller for the single-cycle/multi-cycle CPU's word-organised data memory, which has a combinational read and a write on the rising clock edge. It takes byte, halfword and word load/store requests from the datapath and sequences memory reads, writes and read-modify-writes. It returns aligned, sign- or zero-extended load data and a one-cycle completion pulse. It sits between the execute stage and the data memory.

## Interface

Parameters:
- DATA_SEG_BEGIN, 32'h1000, byte address of the first data-segment word.
- DATA_SEG_SIZE, 32'h100000, data-segment size in words.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is reserved and treated as word.
- unsigned_ld  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; high = access faulted and memory was untouched.
- rdata  out  32  load result; holds its value until the next successful load.
- mem_address  out  32  word index = (addr - DATA_SEG_BEGIN) >> 2.
- mem_write_data  out  32  word to be written.
- mem_memwrite  out  1  write enable.
- mem_memread  out  1  read enable.
- mem_read_data  in  32  combinational read data.

## Operation

- FSM states: IDLE, READ, WRITE, DONE.
- Request data handling:
  - addr, we, size, unsigned_ld and wdata are registered when req is accepted in IDLE.
  - Later changes to these inputs have no effect on the request in progress.
- Transitions from IDLE on req=1:
  - fault → DONE with err=1.
  - load → READ.
  - word store → WRITE.
  - byte/halfword store → READ.
- Later transitions:
  - READ → DONE for a load; load data is captured at the end of READ.
  - READ → WRITE for a sub-word store; the old word is captured at the end of READ.
  - WRITE → DONE.
  - DONE → IDLE unconditionally.
- Memory control: mem_memread is high only in READ; mem_memwrite is high only in WRITE.
- Byte lanes are little-endian and selected by addr[1:0]:
  - byte lane = addr[1:0].
  - halfword lane = addr[1].
  - Sub-word stores merge wdata[7:0] or wdata[15:0] into the captured word; all other bytes are preserved.
- Fault conditions:
  - addr < DATA_SEG_BEGIN, or word index ≥ DATA_SEG_SIZE.
  - misalignment, when trapping is enabled (see Configuration).
  - On a fault: no mem_memread or mem_memwrite is issued and rdata is unchanged.
- req arriving while busy is ignored and is not queued.

## Timing

- Reset values: busy=0, done=0, err=0, rdata=0, mem_memwrite=0, mem_memread=0, mem_address=0, mem_write_data=0, state=IDLE.
- Latency, with req accepted at edge k:
  - fault: done high during cycle k+1.
  - load: READ during k+1, done high during k+2.
  - word store: WRITE during k+1, memory updated at edge k+2, done high during k+2.
  - sub-word store: READ k+1, WRITE k+2, done high during k+3.
- A new req may be accepted at the edge ending DONE+1, i.e. back-to-back with one IDLE cycle.
- rdata changes at the same edge that raises done.
- Reset asserted mid-operation: mem_memwrite drops immediately (asynchronously), so no write is committed. A pending done is discarded.

## Configuration

- LSU_MISALIGN_TRAP_EN defined:
  - halfword with addr[0]=1 faults.
  - word with addr[1:0]≠0 faults.
- LSU_MISALIGN_TRAP_EN undefined:
  - halfword ignores addr[0]; word ignores addr[1:0].
  - Misalignment never sets err.

## Structure

- lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - the state enum.
  - the default values of DATA_SEG_BEGIN and DATA_SEG_SIZE.
- One sub-module, lsu_lane_align: purely combinational.
  - Load side: extract and extend a lane.
  - Store side: merge a lane into a word.
- The FSM and registers stay in load_store_unit.

## Test plan

- Word store then load: store 0xDEADBEEF to 0x1004. Memory word 1 = 0xDEADBEEF at k+2. A load of 0x1004 gives rdata = 0xDEADBEEF with done at k+2.
- Byte RMW: word 1 = 0x11223344; store byte 0xAA to 0x1006. Word becomes 0x11AA3344 with done at k+3. A signed byte load of 0x1006 gives 0xFFFFFFAA; with unsigned_ld it gives 0x000000AA.
- Halfword load: word 1 = 0x8001_7FFF. A signed load of 0x1006 gives 0xFFFF8001; a load of 0x1004 gives 0x00007FFF.
- Faults:
  - load of 0x0FFC: done and err at k+1, no mem_memread pulse.
  - with LSU_MISALIGN_TRAP_EN, word store to 0x1002: err=1, memory unchanged.
  - without the macro, the same store writes word 0.
- req held high while busy: only one access is performed per request, and a second req issued on the DONE cycle is not accepted.
- rst_n pulled low during the WRITE of a byte store: mem_memwrite drops the same cycle, the memory word is unchanged, and all outputs return to their reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and default data-segment geometry for the
// load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] DEF_DATA_SEG_BEGIN = 32'h0000_1000;
  localparam logic [31:0] DEF_DATA_SEG_SIZE  = 32'h0010_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Encoding 3 is reserved and behaves as a word access.
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: extracts/extends a load lane and merges a
// store lane into an existing word (little-endian lanes).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        unsigned_ld,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    ld_data = rd_word;
    merged  = wdata;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
        merged  = rd_word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
        merged  = rd_word;
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: begin
        ld_data = rd_word;
        merged  = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer for a word-organised data memory with combinational
// read. Optional macro LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] DATA_SEG_BEGIN = DEF_DATA_SEG_BEGIN,
  parameter logic [31:0] DATA_SEG_SIZE  = DEF_DATA_SEG_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data
);

  state_t      state, state_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_fault;

  logic [31:0] offset;
  logic [31:0] word_index;
  logic        misalign;
  logic        fault;
  logic        accept;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign offset     = addr - DATA_SEG_BEGIN;
  assign word_index = offset >> 2;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == SZ_HALF) && addr[0]) ||
                    (is_word(size) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault  = (addr < DATA_SEG_BEGIN) || (word_index >= DATA_SEG_SIZE) || misalign;
  assign accept = (state == ST_IDLE) && req;

  lsu_lane_align u_align (
    .size        (r_size),
    .lane        (r_lane),
    .unsigned_ld (r_unsigned),
    .rd_word     (mem_read_data),
    .wdata       (r_wdata),
    .ld_data     (ld_data),
    .merged      (merged)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Memory strobes decode straight from the state register, so an async
  // reset kills a write in progress without waiting for an edge.
  always_comb begin
    state_next   = state;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (fault)                   state_next = ST_DONE;
          else if (!we || !is_word(size)) state_next = ST_READ;
          else                         state_next = ST_WRITE;
        end
      end
      ST_READ: begin
        mem_memread = 1'b1;
        state_next  = r_we ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        mem_memwrite = 1'b1;
        state_next   = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        err        = r_fault;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset; there is no storage array here
  // that would justify leaving any of them uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we           <= 1'b0;
      r_size         <= SZ_BYTE;
      r_unsigned     <= 1'b0;
      r_lane         <= 2'b00;
      r_wdata        <= 32'h0;
      r_fault        <= 1'b0;
      rdata          <= 32'h0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      if (accept) begin
        r_we       <= we;
        r_size     <= size;
        r_unsigned <= unsigned_ld;
        r_lane     <= addr[1:0];
        r_wdata    <= wdata;
        r_fault    <= fault;
        if (!fault) begin
          mem_address    <= word_index;
          mem_write_data <= wdata;
        end
      end
      if (state == ST_READ) begin
        if (r_we) mem_write_data <= merged;
        else      rdata          <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference memory model predicts
// result, latency and strobe counts for each request.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .we             (we),
    .size           (size),
    .unsigned_ld    (unsigned_ld),
    .addr           (addr),
    .wdata          (wdata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_read_data  (mem_read_data)
  );

  logic [31:0] mem [16] = '{default: 32'h0};
  assign mem_read_data = mem[mem_address[3:0]];
  always @(posedge clk) if (mem_memwrite) mem[mem_address[3:0]] <= mem_write_data;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  logic [31:0] exp_rdata = 32'h0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
    logic f;
    f = (a < 32'h1000) || (((a - 32'h1000) >> 2) >= 32'h0010_0000);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd1 && a[0]) f = 1'b1;
    if (sz[1] && a[1:0] != 2'b00) f = 1'b1;
`endif
    return f;
  endfunction

  task automatic access(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    exp_t        e;
    logic [31:0] off, word, v, mask, nw;
    logic [3:0]  ix;
    logic        f, eq;
    int          cyc, nrd, nwr, sh;

    f    = model_fault(sz, a);
    off  = a - 32'h1000;
    ix   = off[5:2];
    word = ref_mem[ix];
    if (sz == 2'd0) begin
      sh   = 8 * int'(a[1:0]);
      v    = word >> sh;
      v    = uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      mask = 32'h0000_00FF << sh;
      nw   = (word & ~mask) | ((wd & 32'h0000_00FF) << sh);
    end else if (sz == 2'd1) begin
      sh   = a[1] ? 16 : 0;
      v    = word >> sh;
      v    = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      mask = 32'h0000_FFFF << sh;
      nw   = (word & ~mask) | ((wd & 32'h0000_FFFF) << sh);
    end else begin
      v  = word;
      nw = wd;
    end
    e.err = f;
    e.lat = f ? 1 : (w && !sz[1]) ? 3 : 2;
    e.nrd = (f || (w && sz[1])) ? 0 : 1;
    e.nwr = (!f && w) ? 1 : 0;
    if (!f && !w) exp_rdata = v;
    if (!f && w)  ref_mem[ix] = nw;
    e.rdata = exp_rdata;
    exp_q.push_back(e);

    req = 1'b1; we = w; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    we = ~w; addr = $urandom; wdata = $urandom;
    size = 2'($urandom_range(0, 3)); unsigned_ld = ~uns;

    cyc = 0; nrd = 0; nwr = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_memread)  nrd++;
      if (mem_memwrite) nwr++;
    end while (!done && cyc < 8);
    check("done_seen", {31'b0, done}, 32'd1);

    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      check("latency", cyc, e.lat);
      check("err", {31'b0, err}, {31'b0, e.err});
      check("rdata", rdata, e.rdata);
      check("reads", nrd, e.nrd);
      check("writes", nwr, e.nwr);
    end
    eq = 1'b1;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) eq = 1'b0;
    check("memory", {31'b0, eq}, 32'd1);

    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_done", {31'b0, done}, 32'd0);
    if (hold) req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},  {31'b0, busy}, 32'd0);
    check({pfx, "_done"},  {31'b0, done}, 32'd0);
    check({pfx, "_err"},   {31'b0, err}, 32'd0);
    check({pfx, "_rdata"}, rdata, 32'd0);
    check({pfx, "_mwr"},   {31'b0, mem_memwrite}, 32'd0);
    check({pfx, "_mrd"},   {31'b0, mem_memread}, 32'd0);
    check({pfx, "_maddr"}, mem_address, 32'd0);
    check({pfx, "_mwdat"}, mem_write_data, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    access(1, SZ_WORD, 0, 32'h1004, 32'hDEAD_BEEF, 0);
    access(0, SZ_WORD, 0, 32'h1004, 32'h0, 0);

    access(1, SZ_WORD, 0, 32'h1004, 32'h1122_3344, 0);
    access(1, SZ_BYTE, 0, 32'h1006, 32'hFFFF_FFAA, 0);
    access(0, SZ_BYTE, 0, 32'h1006, 32'h0, 0);
    access(0, SZ_BYTE, 1, 32'h1006, 32'h0, 0);

    access(1, SZ_WORD, 0, 32'h1004, 32'h8001_7FFF, 0);
    access(0, SZ_HALF, 0, 32'h1006, 32'h0, 0);
    access(0, SZ_HALF, 0, 32'h1004, 32'h0, 0);
    access(0, SZ_HALF, 1, 32'h1006, 32'h0, 0);

    access(1, SZ_HALF, 0, 32'h100A, 32'h1234_BEEF, 0);
    access(1, SZ_BYTE, 0, 32'h1008, 32'h0000_0077, 0);
    access(1, SZ_BYTE, 0, 32'h100B, 32'h0000_0099, 0);
    access(0, SZ_BYTE, 0, 32'h100B, 32'h0, 0);
    access(0, 2'd3,    0, 32'h1008, 32'h0, 0);

    access(0, SZ_WORD, 0, 32'h0FFC, 32'h0, 0);
    access(1, SZ_WORD, 0, 32'h0040_1000, 32'hCAFE_F00D, 0);
    access(1, SZ_WORD, 0, 32'h0040_0FFC, 32'hA5A5_5A5A, 0);
    access(0, SZ_WORD, 0, 32'h0040_0FFC, 32'h0, 0);

    access(1, SZ_WORD, 0, 32'h1002, 32'h1234_5678, 0);
    access(0, SZ_HALF, 0, 32'h1007, 32'h0, 0);
    access(0, SZ_WORD, 0, 32'h1001, 32'h0, 0);

    access(1, SZ_WORD, 0, 32'h100C, 32'h0BAD_F00D, 1);

    // Reset pulled during the WRITE of a byte store.
    req = 1'b1; we = 1'b1; size = SZ_BYTE; unsigned_ld = 1'b0;
    addr = 32'h1006; wdata = 32'h0000_0055;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mwr", {31'b0, mem_memwrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    check("midrst_mem", mem[1], ref_mem[1]);
    rst_n = 1'b1;
    exp_rdata = 32'h0;
    @(negedge clk);
    access(0, SZ_WORD, 0, 32'h1004, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
